// File: rtl/mem_access_unit.sv
// Load/store controller: sub-word LEGv8 loads/stores onto a 64-bit doubleword RAM.
// Optional feature macro: LSU_ALIGN_CHECK_EN (misalignment becomes an error instead of rounding down).
module mem_access_unit #(
   parameter int unsigned MEM_WORDS = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [63:0] req_addr,
   input  logic [63:0] req_wdata,
   output logic        resp_valid,
   output logic [63:0] resp_rdata,
   output logic        resp_err,
   output logic [63:0] mem_addr,
   output logic        mem_read_en,
   output logic        mem_write_en,
   output logic [63:0] mem_wdata,
   input  logic [63:0] mem_rdata
);

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StResp} state_e;

   state_e      state_q, state_d;
   logic        write_q, write_d;
   logic [1:0]  size_q, size_d;
   logic        signed_q, signed_d;
   logic [63:0] addr_q, addr_d;
   logic [63:0] wdata_q, wdata_d;
   logic [63:0] rdata_q, rdata_d;
   logic        resp_valid_d, resp_err_d;
   logic [63:0] resp_rdata_d;

   // Low address bits that must be zero for a naturally aligned access of this size.
   function automatic logic [2:0] size_mask(input logic [1:0] size);
      return 3'((4'd1 << size) - 4'd1);
   endfunction

   logic req_err;
   always_comb begin
      req_err = (req_addr >> 3) >= 64'(MEM_WORDS);
`ifdef LSU_ALIGN_CHECK_EN
      if ((req_addr[2:0] & size_mask(req_size)) != 3'd0) req_err = 1'b1;
`endif
   end

   // Offset rounded down to size alignment; a no-op when alignment is enforced.
   logic [2:0]  off;
   logic [5:0]  shamt;
   logic [63:0] lane;
   logic [63:0] load_data;
   logic [3:0]  nbytes;
   logic [7:0]  lane_mask;
   logic [7:0]  byte_en;
   logic [63:0] wdata_sh;

   always_comb begin
      off       = addr_q[2:0] & ~size_mask(size_q);
      shamt     = {off, 3'b000};
      lane      = mem_rdata >> shamt;
      nbytes    = 4'd1 << size_q;
      lane_mask = 8'((9'd1 << nbytes) - 9'd1);
      byte_en   = lane_mask << off;
      wdata_sh  = wdata_q << shamt;
      case (size_q)
         2'd0:    load_data = signed_q ? {{56{lane[7]}}, lane[7:0]}   : {56'd0, lane[7:0]};
         2'd1:    load_data = signed_q ? {{48{lane[15]}}, lane[15:0]} : {48'd0, lane[15:0]};
         2'd2:    load_data = signed_q ? {{32{lane[31]}}, lane[31:0]} : {32'd0, lane[31:0]};
         default: load_data = lane;
      endcase
      for (int k = 0; k < 8; k++) begin
         mem_wdata[8*k +: 8] = byte_en[k] ? wdata_sh[8*k +: 8] : rdata_q[8*k +: 8];
      end
   end

   always_comb begin
      state_d      = state_q;
      write_d      = write_q;
      size_d       = size_q;
      signed_d     = signed_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = 64'd0;
      case (state_q)
         StIdle: begin
            if (req_valid) begin
               write_d  = req_write;
               size_d   = req_size;
               signed_d = req_signed;
               addr_d   = req_addr;
               wdata_d  = req_wdata;
               if (req_err) begin
                  state_d      = StResp;
                  resp_valid_d = 1'b1;
                  resp_err_d   = 1'b1;
               end else if (req_write && req_size == 2'b11) begin
                  state_d = StWrite;
               end else begin
                  state_d = StRead;
               end
            end
         end
         StRead: begin
            rdata_d = mem_rdata;
            if (write_q) begin
               state_d = StWrite;
            end else begin
               state_d      = StResp;
               resp_valid_d = 1'b1;
               resp_rdata_d = load_data;
            end
         end
         StWrite: begin
            state_d      = StResp;
            resp_valid_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         write_q    <= 1'b0;
         size_q     <= 2'd0;
         signed_q   <= 1'b0;
         addr_q     <= 64'd0;
         wdata_q    <= 64'd0;
         rdata_q    <= 64'd0;
         resp_valid <= 1'b0;
         resp_err   <= 1'b0;
         resp_rdata <= 64'd0;
      end else begin
         state_q    <= state_d;
         write_q    <= write_d;
         size_q     <= size_d;
         signed_q   <= signed_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         rdata_q    <= rdata_d;
         resp_valid <= resp_valid_d;
         resp_err   <= resp_err_d;
         resp_rdata <= resp_rdata_d;
      end
   end

   assign req_ready    = (state_q == StIdle);
   assign mem_addr     = {3'b000, addr_q[63:3]};
   // Gated by reset so an aborted access never touches the RAM.
   assign mem_read_en  = !reset && (state_q == StRead);
   assign mem_write_en = !reset && (state_q == StWrite);

endmodule
